// File: rtl/move_drain_arbiter.sv
// Round-robin drain of local move stacks into global move storage over valid/ready.
// Optional MOVE_NULL_FILTER_EN: captured 16'h0000 moves are dropped instead of forwarded.
`timescale 1ns/1ps
module move_drain_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SRC_W   = 2,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    drain_en,
    input  logic [NUM_SRC-1:0]      src_busy,
    input  logic [NUM_SRC-1:0]      src_empty,
    input  logic [16*NUM_SRC-1:0]   src_move,
    output logic [NUM_SRC-1:0]      src_read,
    output logic                    move_valid,
    input  logic                    move_ready,
    output logic [15:0]             move_data,
    output logic [SRC_W-1:0]        move_src,
    output logic                    drain_done,
    output logic [15:0]             move_count
);

    typedef enum logic [1:0] {SCAN, POP, WAIT, HOLD} state_e;

    state_e            state_q, state_d;
    logic [SRC_W-1:0]  rr_q, rr_d;
    logic [SRC_W-1:0]  sel_q, sel_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [15:0]       move_data_q, move_data_d;
    logic [SRC_W-1:0]  move_src_q, move_src_d;
    logic              move_valid_q, move_valid_d;
    logic [15:0]       move_count_q, move_count_d;

    logic [NUM_SRC-1:0] elig;
    logic [SRC_W-1:0]   pick;
    logic               found;
    logic [SRC_W:0]     scan_idx;
    logic [15:0]        cap_move;
    logic [SRC_W-1:0]   sel_inc;
    logic               keep;

    always_comb begin
        elig = ~src_empty & ~src_busy;
    end

    // First eligible stack at or after the rr pointer, wrapping modulo NUM_SRC.
    always_comb begin
        pick     = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            scan_idx = {1'b0, rr_q} + (SRC_W+1)'(k);
            if (scan_idx >= (SRC_W+1)'(NUM_SRC)) begin
                scan_idx = scan_idx - (SRC_W+1)'(NUM_SRC);
            end
            if (!found && elig[scan_idx[SRC_W-1:0]]) begin
                found = 1'b1;
                pick  = scan_idx[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        cap_move = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (sel_q == SRC_W'(i)) begin
                cap_move = src_move[16*i +: 16];
            end
        end
    end

    always_comb begin
        sel_inc = (sel_q == SRC_W'(NUM_SRC-1)) ? '0 : sel_q + SRC_W'(1);
        keep    = 1'b1;
`ifdef MOVE_NULL_FILTER_EN
        keep    = (cap_move != 16'h0000);
`endif
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        move_data_d  = move_data_q;
        move_src_d   = move_src_q;
        move_valid_d = move_valid_q;
        move_count_d = move_count_q;
        src_read     = '0;
        case (state_q)
            SCAN: begin
                if (drain_en && found) begin
                    sel_d   = pick;
                    state_d = POP;
                end
            end
            POP: begin
                src_read[sel_q] = 1'b1;
                cnt_d           = 2'(RD_LAT);
                state_d         = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 2'd1;
                // cnt_q==1 is the cycle the counter reaches zero and move_out is valid
                if (cnt_q == 2'd1) begin
                    if (keep) begin
                        move_data_d  = cap_move;
                        move_src_d   = sel_q;
                        move_valid_d = 1'b1;
                        state_d      = HOLD;
                    end else begin
                        rr_d    = sel_inc;
                        state_d = SCAN;
                    end
                end
            end
            HOLD: begin
                if (move_ready) begin
                    move_valid_d = 1'b0;
                    move_count_d = move_count_q + 16'd1;
                    rr_d         = sel_inc;
                    state_d      = SCAN;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= SCAN;
            rr_q         <= '0;
            sel_q        <= '0;
            cnt_q        <= '0;
            move_data_q  <= '0;
            move_src_q   <= '0;
            move_valid_q <= 1'b0;
            move_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            move_data_q  <= move_data_d;
            move_src_q   <= move_src_d;
            move_valid_q <= move_valid_d;
            move_count_q <= move_count_d;
        end
    end

    assign move_valid = move_valid_q;
    assign move_data  = move_data_q;
    assign move_src   = move_src_q;
    assign move_count = move_count_q;
    assign drain_done = drain_en && (state_q == SCAN) && (&src_empty);

endmodule

// File: tb/tb_move_drain_arbiter.sv
// Scoreboard bench for move_drain_arbiter: LIFO stack models with RD_LAT read pipe,
// round-robin expectation from eligibility, and a monitor comparing each presented move.
`timescale 1ns/1ps
module tb_move_drain_arbiter;
    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned SRC_W   = 2;
    localparam int unsigned RD_LAT  = 2;
    localparam int unsigned DEPTH   = 16;
`ifdef MOVE_NULL_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        int          src;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  drain_en = 1'b0;
    logic [NUM_SRC-1:0]    src_busy = '0;
    logic [NUM_SRC-1:0]    src_empty;
    logic [16*NUM_SRC-1:0] src_move;
    logic [NUM_SRC-1:0]    src_read;
    logic                  move_valid;
    logic                  move_ready = 1'b0;
    logic [15:0]           move_data;
    logic [SRC_W-1:0]      move_src;
    logic                  drain_done;
    logic [15:0]           move_count;

    always #5 clk = ~clk;

    move_drain_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .drain_en   (drain_en),
        .src_busy   (src_busy),
        .src_empty  (src_empty),
        .src_move   (src_move),
        .src_read   (src_read),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_data  (move_data),
        .move_src   (move_src),
        .drain_done (drain_done),
        .move_count (move_count)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] stk_mem [NUM_SRC][DEPTH];
    int          stk_n   [NUM_SRC];
    logic [15:0] pipe_d  [NUM_SRC][RD_LAT];
    bit          pipe_v  [NUM_SRC][RD_LAT];
    exp_t        sb[$];
    bit          pop_pend  = 1'b0;
    int          pop_idx   = 0;
    bit          inflight_m = 1'b0;
    bit          rand_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int s = 0; s < NUM_SRC; s++) begin
            src_empty[s] = (stk_n[s] == 0);
            src_move[16*s +: 16] = pipe_v[s][RD_LAT-1] ? pipe_d[s][RD_LAT-1] : 16'($urandom);
        end
    endtask

    task automatic push(input int s, input logic [15:0] v);
        if (stk_n[s] < DEPTH) begin
            stk_mem[s][stk_n[s]] = v;
            stk_n[s]++;
        end
        drive();
    endtask

    // One clock: advance the stack read pipes, perform the pop the DUT strobed, apply stimulus.
    task automatic step();
        logic [15:0] v;
        @(posedge clk);
        #1;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int st = RD_LAT-1; st >= 1; st--) begin
                pipe_d[s][st] = pipe_d[s][st-1];
                pipe_v[s][st] = pipe_v[s][st-1];
            end
            pipe_v[s][0] = 1'b0;
        end
        if (pop_pend) begin
            pop_pend = 1'b0;
            if (stk_n[pop_idx] > 0) begin
                stk_n[pop_idx]--;
                v = stk_mem[pop_idx][stk_n[pop_idx]];
                pipe_d[pop_idx][0] = v;
                pipe_v[pop_idx][0] = 1'b1;
                if (!(FILT && v == 16'h0000)) sb.push_back('{data: v, src: pop_idx});
            end
        end
        if (rand_mode) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                src_busy[s] = ($urandom_range(0, 7) == 0);
                if (src_busy[s] && $urandom_range(0, 1) == 1 && stk_n[s] < DEPTH) begin
                    v = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
                    stk_mem[s][stk_n[s]] = v;
                    stk_n[s]++;
                end
            end
            move_ready = ($urandom_range(0, 2) != 0);
            drain_en   = ($urandom_range(0, 15) != 0);
        end
        drive();
    endtask

    function automatic bit all_empty();
        for (int s = 0; s < NUM_SRC; s++) if (stk_n[s] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name, input int max_cyc);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(all_empty() && !inflight_m && !pop_pend) && n < max_cyc);
        if (n >= max_cyc) chk(name, 32'd0, 32'd1);
    endtask

    // Monitor: strobe / arbitration order, latency, held data, count and drain_done.
    initial begin : monitor
        bit                 scan_prev = 1'b0;
        bit                 valid_prev = 1'b0;
        bit                 null_m = 1'b0;
        bit                 start_idle, exp_pop;
        logic [NUM_SRC-1:0] elig_prev = '0;
        logic [NUM_SRC-1:0] rd, exp_rd;
        logic [15:0]        cnt_m = '0;
        exp_t               cur = '{data: 16'h0, src: 0};
        int                 cyc = 0, pop_cyc = 0, cur_idx = 0, rr_m = 0, exp_i, j;
        forever begin
            @(negedge clk);
            if (!rst) begin
                scan_prev = 1'b0; valid_prev = 1'b0; null_m = 1'b0; elig_prev = '0;
                inflight_m = 1'b0; rr_m = 0; cnt_m = '0;
                continue;
            end
            cyc++;
            rd         = src_read;
            start_idle = !inflight_m;
            exp_pop    = scan_prev && (elig_prev != '0);
            exp_i      = -1;
            for (int k = 0; k < NUM_SRC; k++) begin
                j = (rr_m + k) % NUM_SRC;
                if (exp_i < 0 && elig_prev[j]) exp_i = j;
            end
            exp_rd = '0;
            if (exp_pop) exp_rd[exp_i] = 1'b1;
            chk("src_read", 32'(rd), 32'(exp_rd));
            if (rd != '0) begin
                for (int i = NUM_SRC-1; i >= 0; i--) if (rd[i]) cur_idx = i;
                chk("pop_nonempty", 32'(stk_n[cur_idx] != 0), 32'd1);
                null_m     = FILT && (stk_n[cur_idx] != 0) &&
                             (stk_mem[cur_idx][stk_n[cur_idx]-1] == 16'h0000);
                inflight_m = 1'b1;
                pop_cyc    = cyc;
                pop_idx    = cur_idx;
                pop_pend   = 1'b1;
            end
            chk("drain_done", 32'(drain_done), 32'(drain_en && !inflight_m && all_empty()));
            chk("move_count", 32'(move_count), 32'(cnt_m));
            if (inflight_m && !null_m && cyc == pop_cyc + RD_LAT + 1)
                chk("valid_latency", 32'(move_valid), 32'd1);
            if (move_valid) begin
                if (!valid_prev) begin
                    if (sb.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
                    else cur = sb.pop_front();
                end
                chk("move_data", 32'(move_data), 32'(cur.data));
                chk("move_src", 32'(move_src), 32'(cur.src));
                if (move_ready) begin
                    cnt_m      = cnt_m + 16'd1;
                    rr_m       = (cur.src + 1) % NUM_SRC;
                    inflight_m = 1'b0;
                end
            end
            if (null_m && inflight_m) begin
                chk("null_no_valid", 32'(move_valid), 32'd0);
                if (cyc == pop_cyc + RD_LAT) begin
                    inflight_m = 1'b0;
                    null_m     = 1'b0;
                    rr_m       = (cur_idx + 1) % NUM_SRC;
                end
            end
            valid_prev = move_valid && !move_ready;
            scan_prev  = start_idle && (rd == '0);
            elig_prev  = drain_en ? (~src_empty & ~src_busy) : '0;
        end
    end

    initial begin : stimulus
        int n;
        for (int s = 0; s < NUM_SRC; s++) begin
            stk_n[s] = 0;
            for (int st = 0; st < RD_LAT; st++) begin
                pipe_v[s][st] = 1'b0;
                pipe_d[s][st] = '0;
            end
        end
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_src_read", 32'(src_read), 32'd0);
        chk("rst_valid", 32'(move_valid), 32'd0);
        chk("rst_data", 32'(move_data), 32'd0);
        chk("rst_src", 32'(move_src), 32'd0);
        chk("rst_count", 32'(move_count), 32'd0);
        chk("rst_drain_done", 32'(drain_done), 32'd0);
        step();
        rst = 1'b1;

        drain_en = 1'b1;
        repeat (5) step();

        move_ready = 1'b1;
        push(2, 16'hA5C3);
        wait_idle("to_single", 40);

        push(0, 16'h1111);
        wait_idle("to_rr_setup", 40);
        for (int r = 0; r < 4; r++) begin
            push(0, 16'h1000 + 16'(r));
            push(1, 16'h2000 + 16'(r));
            push(3, 16'h3000 + 16'(r));
        end
        wait_idle("to_rr", 200);

        src_busy = 4'b0001;
        push(0, 16'h0BEE);
        repeat (6) step();
        src_busy = '0;
        wait_idle("to_busy", 40);

        move_ready = 1'b0;
        push(1, 16'h7E57);
        n = 0;
        while (!move_valid && n < 20) begin
            step();
            n++;
        end
        chk("hold_reached", 32'(move_valid), 32'd1);
        repeat (10) step();
        move_ready = 1'b1;
        wait_idle("to_hold", 40);

        push(3, 16'h0000);
        wait_idle("to_null", 40);

        push(1, 16'hD00D);
        n = 0;
        while (!inflight_m && n < 20) begin
            step();
            n++;
        end
        drain_en = 1'b0;
        push(2, 16'hCAFE);
        repeat (15) step();
        drain_en = 1'b1;
        wait_idle("to_drain_en", 40);

        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode  = 1'b0;
        src_busy   = '0;
        move_ready = 1'b1;
        drain_en   = 1'b1;
        wait_idle("to_final", 1000);
        repeat (3) step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
